// File: rtl/pe_pkg.sv
// Shared types for the PE job scheduler: opcodes, job descriptor, FSM states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package pe_pkg;

  localparam int PE_OPCODE_LEN = 4;
  localparam int DRAM_DEPTH    = 64;
  localparam int AW            = $clog2(DRAM_DEPTH);

  typedef enum logic [PE_OPCODE_LEN-1:0] {
    NOOP          = 4'd0,
    ADD           = 4'd1,
    SUB           = 4'd2,
    MUL           = 4'd3,
    DOTP          = 4'd4,
    STORE_TEMP_S1 = 4'd5,
    STORE_TEMP_S2 = 4'd6,
    STORE_RESULT  = 4'd7,
    STOP          = 4'd8
  } pe_op_e;

  // op is kept as raw bits: the host may send values outside pe_op_e
  typedef struct packed {
    logic [PE_OPCODE_LEN-1:0] op;
    logic [AW-1:0]            addr_a;
    logic [AW-1:0]            addr_b;
    logic [AW-1:0]            addr_r;
  } pe_job_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WAIT, S_STORE
  } sched_state_e;

  // Only the four vector operations may be issued as jobs
  function automatic logic op_legal(input logic [PE_OPCODE_LEN-1:0] op);
    return op inside {ADD, SUB, MUL, DOTP};
  endfunction

endpackage

// File: rtl/pe_job_fifo.sv
// Synchronous FIFO of job descriptors; flush empties it in one cycle.
// Latency: a pushed entry is visible at dout the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; flush wins.
// Ports: clk/rstn, push/din, pop/dout, flush, full, empty.
module pe_job_fifo
  import pe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    push,
  input  logic    pop,
  input  logic    flush,
  input  pe_job_t din,
  output pe_job_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AWQ = $clog2(DEPTH);

  pe_job_t          mem [DEPTH];
  logic [AWQ-1:0]   wr_ptr;
  logic [AWQ-1:0]   rd_ptr;
  logic [AWQ:0]     count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AWQ+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AWQ'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AWQ'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AWQ+1)'(1);
        2'b01:   count <= count - (AWQ+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_job_scheduler.sv
// Queues vector job descriptors and sequences load/exec/wait/store on the PE.
// Latency: pop to job_done is 6 cycles plus the PE response time in WAIT.
// Backpressure: job_ready = !full && !abort; the FSM pops only from IDLE.
// Ports: job_* host descriptor port; load_a/load_b/data_addr operand loads;
// pe_opcode and pe_stage_*_valid PE handshake; store_result/res_addr result
// write; busy, job_done, job_err status; abort flushes everything.
module pe_job_scheduler
  import pe_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int PE_ELEMENTS = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     abort,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [PE_OPCODE_LEN-1:0] job_op,
  input  logic [AW-1:0]            job_addr_a,
  input  logic [AW-1:0]            job_addr_b,
  input  logic [AW-1:0]            job_addr_r,
  output logic                     load_a,
  output logic                     load_b,
  output logic [AW-1:0]            data_addr,
  output logic [PE_OPCODE_LEN-1:0] pe_opcode,
  input  logic                     pe_stage_1_valid,
  input  logic                     pe_stage_2_valid,
  output logic                     store_result,
  output logic [AW-1:0]            res_addr,
  output logic                     busy,
  output logic                     job_done,
  output logic                     job_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int EW = $clog2(PE_ELEMENTS + 1);

  sched_state_e  state;
  pe_job_t       job;
  pe_job_t       in_job;
  pe_job_t       head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          complete;
  logic [CW-1:0] wait_cnt;
  logic [EW-1:0] s2_cnt;

  assign in_job    = '{op: job_op, addr_a: job_addr_a, addr_b: job_addr_b, addr_r: job_addr_r};
  assign job_ready = !full && !abort;
  assign push      = job_valid && job_ready;
  assign pop       = (state == S_IDLE) && !empty && !abort;
  assign busy      = (state != S_IDLE) || !empty;

  // DOTP finishes on the last reduced scalar; the others on the first
  // element-wise result. Stage-1 valids never complete a DOTP.
  assign complete = (job.op == DOTP)
                  ? (pe_stage_2_valid && (s2_cnt == EW'(PE_ELEMENTS - 1)))
                  : pe_stage_1_valid;

  pe_job_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .din   (in_job),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      job          <= '0;
      load_a       <= 1'b0;
      load_b       <= 1'b0;
      data_addr    <= '0;
      pe_opcode    <= NOOP;
      store_result <= 1'b0;
      res_addr     <= '0;
      job_done     <= 1'b0;
      job_err      <= 1'b0;
      wait_cnt     <= '0;
      s2_cnt       <= '0;
    end else begin
      load_a       <= 1'b0;
      load_b       <= 1'b0;
      store_result <= 1'b0;
      job_done     <= 1'b0;
      job_err      <= 1'b0;
      if (abort) begin
        // A store already on the bus this cycle still lands; its done is dropped
        state     <= S_IDLE;
        pe_opcode <= NOOP;
      end else begin
        case (state)
          S_IDLE: begin
            if (!empty) begin
              job <= head;
              if (op_legal(head.op)) begin
                state     <= S_LOAD_A;
                load_a    <= 1'b1;
                data_addr <= head.addr_a;
              end else begin
                job_err <= 1'b1;
              end
            end
          end
          S_LOAD_A: begin
            state     <= S_LOAD_B;
            load_b    <= 1'b1;
            data_addr <= job.addr_b;
          end
          S_LOAD_B: begin
            state     <= S_EXEC;
            pe_opcode <= job.op;
          end
          S_EXEC: begin
            state    <= S_WAIT;
            wait_cnt <= '0;
            s2_cnt   <= '0;
          end
          S_WAIT: begin
            if (complete) begin
              state        <= S_STORE;
              pe_opcode    <= STORE_RESULT;
              store_result <= 1'b1;
              res_addr     <= job.addr_r;
            end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
              state     <= S_IDLE;
              pe_opcode <= NOOP;
              job_err   <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
              if (job.op == DOTP && pe_stage_2_valid) s2_cnt <= s2_cnt + EW'(1);
            end
          end
          S_STORE: begin
            state     <= S_IDLE;
            pe_opcode <= NOOP;
            job_done  <= 1'b1;
          end
          default: begin
            state     <= S_IDLE;
            pe_opcode <= NOOP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_job_scheduler.sv
module tb_pe_job_scheduler;
  import pe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, abort, job_valid, job_ready;
  logic [3:0] job_op;
  logic [5:0] job_addr_a, job_addr_b, job_addr_r;
  logic load_a, load_b, store_result, busy, job_done, job_err;
  logic [5:0] data_addr, res_addr;
  logic [3:0] pe_opcode;
  logic s1v, s2v;

  pe_job_scheduler dut (
    .clk(clk), .rstn(rstn), .abort(abort),
    .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op),
    .job_addr_a(job_addr_a), .job_addr_b(job_addr_b), .job_addr_r(job_addr_r),
    .load_a(load_a), .load_b(load_b), .data_addr(data_addr), .pe_opcode(pe_opcode),
    .pe_stage_1_valid(s1v), .pe_stage_2_valid(s2v),
    .store_result(store_result), .res_addr(res_addr),
    .busy(busy), .job_done(job_done), .job_err(job_err)
  );

  // Behavioural model: a job queue plus the age (cycles since pop) of the active job
  typedef struct { int op; int a; int b; int r; } mjob_t;
  mjob_t mq[$];
  bit    m_act, m_st;
  mjob_t m_cur;
  int    m_age, m_s2;
  bit    e_load_a, e_load_b, e_store, e_done, e_err;
  int    e_daddr, e_raddr, e_op;

  int checks = 0, errors = 0;
  int pe_mode = 0;
  bit last_acc;
  int cyc = 0;
  int n_done = 0, n_err = 0, n_store = 0;
  int t_load = -100, t_store = 0, t_done = 0, t_err = 0;
  int r_da = 0, r_db = 0, r_ra = 0, r_exop = 0;
  int optbl[10] = '{1, 2, 3, 4, 1, 2, 3, 4, 0, 9};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit acc, complete;
    mjob_t j;
    e_load_a = 0; e_load_b = 0; e_store = 0; e_done = 0; e_err = 0;
    acc = rstn && job_valid && (mq.size() < 4) && !abort;
    last_acc = acc;
    if (!rstn || abort) begin
      mq.delete(); m_act = 0; m_st = 0; e_op = 0;
      return;
    end
    if (m_act) begin
      if (m_st) begin
        m_act = 0; m_st = 0; e_done = 1;
      end else if (m_age >= 4) begin
        complete = (m_cur.op == 4) ? (s2v && m_s2 == 3) : s1v;
        if (complete) m_st = 1;
        else if (m_age - 3 == 64) begin m_act = 0; e_err = 1; end
        else begin
          m_age++;
          if (m_cur.op == 4 && s2v) m_s2++;
        end
      end else begin
        m_age++; m_s2 = 0;
      end
    end else if (mq.size() > 0) begin
      j = mq.pop_front();
      if (j.op >= 1 && j.op <= 4) begin
        m_act = 1; m_cur = j; m_age = 1; m_st = 0;
      end else e_err = 1;
    end
    if (acc) begin
      j.op = int'(job_op); j.a = int'(job_addr_a); j.b = int'(job_addr_b); j.r = int'(job_addr_r);
      mq.push_back(j);
    end
    e_load_a = m_act && !m_st && m_age == 1;
    e_load_b = m_act && !m_st && m_age == 2;
    e_daddr  = (m_age == 1) ? m_cur.a : m_cur.b;
    e_store  = m_st;
    e_raddr  = m_cur.r;
    e_op     = !m_act ? 0 : m_st ? 7 : (m_age >= 3) ? m_cur.op : 0;
  endtask

  // One clock: drive PE valids, check job_ready, advance model, compare outputs
  task automatic tick();
    bit busy_exp;
    case (pe_mode)
      0: begin s1v = ($urandom % 4 == 0); s2v = ($urandom % 3 == 0); end
      1: begin s1v = m_act && !m_st && m_age == 5; s2v = 0; end
      3: begin
        s1v = m_act && !m_st && m_age == 6;
        s2v = m_act && !m_st && (m_age inside {2, 3, 4, 5, 8, 9});
      end
      default: begin s1v = 0; s2v = 0; end
    endcase
    #1;
    chk("job_ready", int'(job_ready), int'(mq.size() < 4 && !abort));
    model_step();
    busy_exp = m_act || mq.size() > 0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("load_a", int'(load_a), int'(e_load_a));
    chk("load_b", int'(load_b), int'(e_load_b));
    chk("store_result", int'(store_result), int'(e_store));
    chk("job_done", int'(job_done), int'(e_done));
    chk("job_err", int'(job_err), int'(e_err));
    chk("pe_opcode", int'(pe_opcode), e_op);
    chk("busy", int'(busy), int'(busy_exp));
    if (e_load_a || e_load_b) chk("data_addr", int'(data_addr), e_daddr);
    if (e_store) chk("res_addr", int'(res_addr), e_raddr);
    if (load_a) begin t_load = cyc; r_da = int'(data_addr); end
    if (load_b) r_db = int'(data_addr);
    if (cyc == t_load + 2) r_exop = int'(pe_opcode);
    if (store_result) begin t_store = cyc; r_ra = int'(res_addr); n_store++; end
    if (job_done) begin t_done = cyc; n_done++; end
    if (job_err) begin t_err = cyc; n_err++; end
  endtask

  task automatic send(input int op, input int a, input int b, input int r);
    bit got = 0;
    job_valid = 1; job_op = 4'(op);
    job_addr_a = 6'(a); job_addr_b = 6'(b); job_addr_r = 6'(r);
    for (int k = 0; k < 60; k++) begin
      tick();
      if (last_acc) begin got = 1; break; end
    end
    job_valid = 0;
    chk("send_accepted", int'(got), 1);
  endtask

  task automatic wait_idle(input int bound);
    bit got = 0;
    for (int k = 0; k < bound; k++) begin
      if (!m_act && mq.size() == 0) begin got = 1; break; end
      tick();
    end
    chk("idle_reached", int'(got), 1);
  endtask

  initial begin
    int d0, e0, st0;
    bit got;
    rstn = 0; abort = 0; job_valid = 0; job_op = 0;
    job_addr_a = 0; job_addr_b = 0; job_addr_r = 0; s1v = 0; s2v = 0;
    m_act = 0; m_st = 0; m_age = 0; m_s2 = 0; e_op = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    #1;
    // Reset state
    chk("rst_job_ready", int'(job_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pe_opcode", int'(pe_opcode), 0);
    chk("rst_strobes", int'({load_a, load_b, store_result, job_done, job_err}), 0);
    chk("rst_addrs", int'({data_addr, res_addr}), 0);
    @(negedge clk);

    // Single ADD, stage-1 valid two cycles after EXEC
    pe_mode = 1;
    send(1, 3, 5, 7);
    wait_idle(40);
    chk("add_addr_a", r_da, 3);
    chk("add_addr_b", r_db, 5);
    chk("add_exec_op", r_exop, 1);
    chk("add_res_addr", r_ra, 7);
    chk("add_store_lat", t_store - t_load, 5);
    chk("add_done_lat", t_done - t_load, 6);
    chk("add_busy_after", int'(busy), 0);

    // DOTP with spaced stage-2 pulses plus stray valids
    pe_mode = 3; st0 = n_store; d0 = n_done;
    send(4, 10, 11, 12);
    wait_idle(60);
    chk("dotp_stores", n_store - st0, 1);
    chk("dotp_store_lat", t_store - t_load, 9);
    chk("dotp_done", n_done - d0, 1);
    chk("dotp_res_addr", r_ra, 12);

    // Fill the queue behind a running job
    pe_mode = 1; d0 = n_done;
    send(1, 1, 2, 3);
    for (int i = 1; i <= 5; i++) begin
      send((i % 3) + 1, i, i + 30, 20 + i);
      if (i == 4) chk("full_job_ready", int'(job_ready), 0);
    end
    wait_idle(200);
    chk("fill_done_count", n_done - d0, 6);
    chk("fill_last_res", r_ra, 25);

    // Illegal op followed by a normal job
    e0 = n_err; d0 = n_done;
    send(9, 1, 1, 1);
    send(2, 4, 5, 6);
    wait_idle(60);
    chk("illegal_err", n_err - e0, 1);
    chk("illegal_next_done", n_done - d0, 1);
    chk("illegal_next_res", r_ra, 6);

    // Timeout then a completing job
    pe_mode = 2; e0 = n_err; d0 = n_done;
    send(1, 7, 8, 9);
    send(3, 1, 1, 33);
    got = 0;
    for (int k = 0; k < 150; k++) begin
      if (n_err != e0) begin got = 1; break; end
      tick();
    end
    chk("timeout_seen", int'(got), 1);
    chk("timeout_lat", t_err - t_load, 67);
    pe_mode = 1;
    wait_idle(60);
    chk("timeout_next_done", n_done - d0, 1);
    chk("timeout_next_res", r_ra, 33);

    // Abort in WAIT with two jobs queued
    pe_mode = 2; st0 = n_store; d0 = n_done; e0 = n_err;
    send(2, 1, 2, 40);
    send(1, 1, 2, 41);
    send(3, 1, 2, 42);
    for (int k = 0; k < 20 && !(m_act && m_age >= 6); k++) tick();
    abort = 1; tick(); abort = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_opcode", int'(pe_opcode), 0);
    repeat (8) tick();
    chk("abort_no_store", n_store - st0, 0);
    chk("abort_no_done_err", (n_done - d0) + (n_err - e0), 0);

    // Abort during STORE: store lands, done is suppressed
    pe_mode = 1; st0 = n_store; d0 = n_done;
    send(1, 2, 3, 50);
    for (int k = 0; k < 20 && !m_st; k++) tick();
    abort = 1; tick(); abort = 0;
    repeat (3) tick();
    chk("abort_store_stored", n_store - st0, 1);
    chk("abort_store_no_done", n_done - d0, 0);

    // Reset in LOAD_B with a job queued
    d0 = n_done;
    send(1, 4, 4, 44);
    send(2, 4, 4, 45);
    for (int k = 0; k < 20 && !(m_act && m_age == 2); k++) tick();
    rstn = 0; tick(); rstn = 1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_opcode", int'(pe_opcode), 0);
    repeat (10) tick();
    chk("rst_mid_no_done", n_done - d0, 0);

    // Randomized traffic
    pe_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      job_valid  = ($urandom % 2 == 0);
      job_op     = 4'(optbl[$urandom % 10]);
      job_addr_a = 6'($urandom); job_addr_b = 6'($urandom); job_addr_r = 6'($urandom);
      abort      = ($urandom % 80 == 0);
      rstn       = !($urandom % 400 == 0);
      tick();
    end
    job_valid = 0; abort = 0; rstn = 1;
    wait_idle(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pe_job_scheduler.md
Name: pe_job_scheduler

Overview:
Sequences the PE datapath on behalf of a host. It accepts vector job descriptors (op, A/B/result addresses) through a valid/ready port and queues them in a 4-entry FIFO. For each job it drives the load, execute, wait and store steps, and reports completion or error per job. It replaces hand-written instruction streams for ADD/SUB/MUL/DOTP.

Parameters:
PE_OPCODE_LEN, 4, width of the PE opcode bus and of the job op field
DRAM_DEPTH, 64, vector entries per operand/result memory; address width AW = $clog2(DRAM_DEPTH)
QUEUE_DEPTH, 4, job FIFO entries (power of 2, >=2)
PE_ELEMENTS, 4, lanes; number of stage-2 valids per DOTP
TIMEOUT, 64, max WAIT cycles before an error is flagged

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
abort  in  1  flush queue and drop the in-flight job
job_valid  in  1  descriptor valid
job_ready  out  1  FIFO can accept; equals !full && !abort
job_op  in  PE_OPCODE_LEN  1=ADD 2=SUB 3=MUL 4=DOTP; any other value is illegal
job_addr_a  in  AW  operand A entry
job_addr_b  in  AW  operand B entry
job_addr_r  in  AW  result entry
load_a  out  1  one-cycle strobe: latch ram_a[data_addr] into data_a
load_b  out  1  one-cycle strobe: latch ram_b[data_addr] into data_b
data_addr  out  AW  operand address qualifying load_a/load_b
pe_opcode  out  PE_OPCODE_LEN  opcode to the PE array; 0 (NOOP) when idle
pe_stage_1_valid  in  1  element-wise result ready
pe_stage_2_valid  in  1  one reduced scalar ready
store_result  out  1  one-cycle strobe: write result to res_addr
res_addr  out  AW  result address, held stable while store_result=1
busy  out  1  FSM not IDLE or FIFO not empty
job_done  out  1  one-cycle pulse per successfully stored job
job_err  out  1  one-cycle pulse per illegal-op or timed-out job

Behaviour:
- Reset (rstn=0 at clk edge): FSM=IDLE, FIFO empty. All outputs are 0, except job_ready, which is 1.
- Enqueue happens when job_valid && job_ready. A full FIFO holds job_ready low. Enqueue and dequeue in the same cycle while full is allowed only if the dequeue is visible combinationally; it is not required, so job_ready = !full.
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, WAIT, STORE.
- IDLE: if the FIFO is non-empty, pop the head into the job register.
  - Legal op -> LOAD_A.
  - Illegal op -> job_err pulse next cycle, stay IDLE.
- LOAD_A, 1 cycle: load_a=1, data_addr=addr_a. Then LOAD_B.
- LOAD_B, 1 cycle: load_b=1, data_addr=addr_b. Then EXEC.
- EXEC, 1 cycle: pe_opcode=job_op. Clear the wait counter and stage-2 count. Then WAIT.
- WAIT: pe_opcode=job_op held. The wait counter increments every cycle.
  - ADD/SUB/MUL: first pe_stage_1_valid -> STORE.
  - DOTP: count pe_stage_2_valid pulses; the PE_ELEMENTS-th pulse -> STORE. Stage-1 valids are ignored for DOTP.
  - Counter reaching TIMEOUT without completion -> job_err pulse, IDLE, no store.
- STORE, 1 cycle: pe_opcode=7, store_result=1, res_addr=addr_r. The next cycle pulses job_done; the FSM returns to IDLE in the same cycle.
- For DOTP, the store is issued one cycle after the last stage-2 valid so the shifted-in scalar is settled.
- Minimum job latency, IDLE pop to job_done: 6 cycles plus the PE latency.
- Back-to-back jobs: IDLE may pop on the cycle after STORE; no bubble beyond the IDLE cycle.
- Valids arriving in IDLE/LOAD/EXEC are ignored.
- abort (sampled at clk edge):
  - FIFO emptied, FSM forced to IDLE, pe_opcode=0, no store, no job_done, no job_err.
  - abort wins over a simultaneous job_valid (job_ready=0).
  - abort during STORE still lets that cycle's store_result take effect. The store and abort are in the same edge, so the store completes but job_done is suppressed.
- Reset mid-job: identical to abort plus all pulses cleared.
- FIFO pointers are AW_Q=$clog2(QUEUE_DEPTH) bits wide and wrap modulo QUEUE_DEPTH. The occupancy counter is AW_Q+1 bits.

Decomposition:
- Shared package pe_pkg holds:
  - typedef pe_op_e: NOOP=0, ADD=1, SUB=2, MUL=3, DOTP=4, STORE_TEMP_S1=5, STORE_TEMP_S2=6, STORE_RESULT=7, STOP=8.
  - typedef pe_job_t: packed struct of op and addresses.
  - typedef sched_state_e.
- Sub-module pe_job_fifo: a synchronous FIFO of pe_job_t with push, pop, flush, full and empty.

Test Plan:
- Single ADD job (a=3, b=5, r=7); PE asserts stage_1_valid 2 cycles after EXEC.
  - load_a with addr 3, then load_b with addr 5, pe_opcode=1.
  - store_result with res_addr=7, job_done 1 cycle later; busy low afterwards.
- DOTP job; 4 stage_2_valid pulses spaced 1 and 3 cycles apart -> exactly one store after the 4th pulse, then job_done.
- 5 jobs pushed back-to-back with no pops possible -> job_ready drops after the 4th; all 5 complete in order with the correct res_addr values.
- job_op=9 -> job_err pulse, no load/store strobes, next queued job proceeds normally.
- No valid returned -> job_err after 64 WAIT cycles, no store; the following job completes.
- abort asserted in WAIT with 2 jobs queued -> IDLE next cycle, pe_opcode=0, no store/done, queue empty; rstn=0 mid-LOAD_B gives the same outcome.
